// File: rtl/axi_sdram_stream_wr_dma.sv
// AXIS-to-AXI write DMA: buffers a word stream and issues INCR bursts (capped at BURST_LEN
// and at 4KB boundaries) into axi_sdram, reporting completion and sticky B errors.
module axi_sdram_stream_wr_dma #(
    parameter int DATA_WIDTH = 16,
    parameter int BURST_LEN  = 256,
    parameter int BUF_DEPTH  = 512,
    parameter int MAX_OUTSTD = 2,
    parameter int SIM_DELAY  = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [31:0]             base_addr,
    input  logic [23:0]             xfer_words,
    output logic                    idle,
    output logic                    done,
    output logic                    bresp_err,
    input  logic [DATA_WIDTH-1:0]   s_axis_data,
    input  logic                    s_axis_valid,
    output logic                    s_axis_ready,
    output logic [31:0]             m_axi_awaddr,
    output logic [7:0]              m_axi_awlen,
    output logic [2:0]              m_axi_awsize,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wlast,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int SZ    = $clog2(BYTES);
    localparam int FAW   = $clog2(BUF_DEPTH);
    localparam int CW    = FAW + 1;

    if (BURST_LEN < 2 || BURST_LEN > 256 || BUF_DEPTH < BURST_LEN ||
        (BUF_DEPTH & (BUF_DEPTH - 1)) != 0 || MAX_OUTSTD < 1 || MAX_OUTSTD > 4 ||
        SIM_DELAY < 0) begin : g_bad_params
        $error("axi_sdram_stream_wr_dma: illegal parameter combination");
    end

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT_B, S_DONE} state_t;
    state_t state, state_nx;

    logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
    logic [CW-1:0]  wr_ptr, rd_ptr, fifo_cnt, reserved, unreserved;
    logic [31:0]    addr;
    logic [23:0]    xfer_len, words_in, issue_left;
    logic [23:0]    len_cap, burst_words;
    logic [12:0]    beats_4k;
    logic [2:0]     outstd;
    logic [7:0]     q_len [4];
    logic [1:0]     q_head, q_tail;
    logic [2:0]     q_cnt;
    logic [7:0]     beat;
    logic           aw_ok, aw_hs, w_hs, w_pop, b_hs, push, start_ok;

    function automatic logic [1:0] q_next(input logic [1:0] i);
        return (i == 2'(MAX_OUTSTD - 1)) ? 2'd0 : i + 2'd1;
    endfunction

    assign fifo_cnt   = wr_ptr - rd_ptr;
    // Words already promised to issued bursts are excluded so each AW is backed by data.
    assign unreserved = fifo_cnt - reserved;

    assign beats_4k    = (13'h1000 - {1'b0, addr[11:0]}) >> SZ;
    assign len_cap     = (issue_left < 24'(BURST_LEN)) ? issue_left : 24'(BURST_LEN);
    assign burst_words = (len_cap < {11'd0, beats_4k}) ? len_cap : {11'd0, beats_4k};

    assign aw_ok = (state == S_RUN) && (issue_left != '0) && (outstd < 3'(MAX_OUTSTD)) &&
                   (q_cnt < 3'(MAX_OUTSTD)) && (24'(unreserved) >= burst_words);

    assign m_axi_awvalid = aw_ok;
    assign m_axi_awaddr  = addr;
    assign m_axi_awlen   = aw_ok ? 8'(burst_words - 24'd1) : '0;
    assign m_axi_awsize  = aw_ok ? 3'(SZ) : '0;

    assign m_axi_wvalid = (state == S_RUN) && (q_cnt != '0) && (fifo_cnt != '0);
    assign m_axi_wlast  = m_axi_wvalid && (beat == q_len[q_head]);
    assign m_axi_wdata  = m_axi_wvalid ? mem[rd_ptr[FAW-1:0]] : '0;
    assign m_axi_wstrb  = m_axi_wvalid ? '1 : '0;
    assign m_axi_bready = (state == S_RUN) || (state == S_WAIT_B);

    assign s_axis_ready = (state == S_RUN) && (fifo_cnt != CW'(BUF_DEPTH)) && (words_in < xfer_len);

    assign aw_hs    = aw_ok && m_axi_awready;
    assign w_hs     = m_axi_wvalid && m_axi_wready;
    assign w_pop    = w_hs && m_axi_wlast;
    assign b_hs     = m_axi_bvalid && m_axi_bready;
    assign push     = s_axis_valid && s_axis_ready;
    assign start_ok = start && (state == S_IDLE);

    assign idle = (state == S_IDLE);
    assign done = (state == S_DONE);

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (start) state_nx = (xfer_words == '0) ? S_DONE : S_RUN;
            S_RUN:    if (issue_left == '0 && q_cnt == '0) state_nx = S_WAIT_B;
            S_WAIT_B: if (outstd == '0) state_nx = S_DONE;
            S_DONE:   state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[FAW-1:0]] <= s_axis_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr       <= '0;
            xfer_len   <= '0;
            issue_left <= '0;
            words_in   <= '0;
            bresp_err  <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            reserved   <= '0;
            outstd     <= '0;
        end else begin
            if (start_ok) begin
                addr       <= base_addr;
                xfer_len   <= xfer_words;
                issue_left <= xfer_words;
                words_in   <= '0;
                bresp_err  <= 1'b0;
            end else begin
                if (aw_hs) begin
                    addr       <= addr + (32'(burst_words) << SZ);
                    issue_left <= issue_left - burst_words;
                end
                if (push) words_in <= words_in + 24'd1;
                if (b_hs && m_axi_bresp != 2'b00) bresp_err <= 1'b1;
            end
            if (push) wr_ptr <= wr_ptr + CW'(1);
            if (w_hs) rd_ptr <= rd_ptr + CW'(1);
            reserved <= reserved + (aw_hs ? CW'(burst_words) : '0) - (w_hs ? CW'(1) : '0);
            case ({aw_hs, b_hs})
                2'b10:   outstd <= outstd + 3'd1;
                2'b01:   outstd <= outstd - 3'd1;
                default: outstd <= outstd;
            endcase
        end
    end

    // Burst-length queue keeps W beats in AW order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 4; i++) q_len[i] <= '0;
            q_head <= '0;
            q_tail <= '0;
            q_cnt  <= '0;
            beat   <= '0;
        end else begin
            if (aw_hs) begin
                q_len[q_tail] <= m_axi_awlen;
                q_tail        <= q_next(q_tail);
            end
            if (w_pop) begin
                q_head <= q_next(q_head);
                beat   <= '0;
            end else if (w_hs) begin
                beat <= beat + 8'd1;
            end
            case ({aw_hs, w_pop})
                2'b10:   q_cnt <= q_cnt + 3'd1;
                2'b01:   q_cnt <= q_cnt - 3'd1;
                default: q_cnt <= q_cnt;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_sdram_stream_wr_dma.sv
// Directed bench for axi_sdram_stream_wr_dma: AXI slave model with AW/W/B scoreboards.
module tb_axi_sdram_stream_wr_dma;
    localparam int DW   = 16;
    localparam int MAXO = 2;
    localparam int DEPTH = 512;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [31:0]   base_addr;
    logic [23:0]   xfer_words;
    logic          idle, done, bresp_err;
    logic [DW-1:0] s_axis_data;
    logic          s_axis_valid, s_axis_ready;
    logic [31:0]   m_axi_awaddr;
    logic [7:0]    m_axi_awlen;
    logic [2:0]    m_axi_awsize;
    logic          m_axi_awvalid, m_axi_awready;
    logic [DW-1:0] m_axi_wdata;
    logic [DW/8-1:0] m_axi_wstrb;
    logic          m_axi_wlast, m_axi_wvalid, m_axi_wready;
    logic [1:0]    m_axi_bresp;
    logic          m_axi_bvalid, m_axi_bready;

    always #5 clk = ~clk;

    axi_sdram_stream_wr_dma #(
        .DATA_WIDTH(DW), .BURST_LEN(256), .BUF_DEPTH(DEPTH), .MAX_OUTSTD(MAXO), .SIM_DELAY(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .xfer_words(xfer_words),
        .idle(idle), .done(done), .bresp_err(bresp_err),
        .s_axis_data(s_axis_data), .s_axis_valid(s_axis_valid), .s_axis_ready(s_axis_ready),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
    );

    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [31:0]   exp_aw_addr[$];
    logic [7:0]    exp_aw_len[$];
    logic [DW-1:0] sb_data[$];
    logic [7:0]    slave_len[$];
    int unsigned   b_due[$];
    logic [1:0]    b_resp[$];
    logic [DW-1:0] data_seq;
    int unsigned   r_max_outst;
    bit            r_full_seen;

    task automatic add_aw(input logic [31:0] a, input logic [7:0] l);
        exp_aw_addr.push_back(a);
        exp_aw_len.push_back(l);
    endtask

    task automatic run_xfer(input logic [31:0] base, input logic [23:0] n,
                            input int unsigned aw_gap, input int unsigned w_gap,
                            input int unsigned bdel, input int unsigned err_at,
                            input int unsigned abort_beat, input logic exp_err);
        int unsigned cyc = 0, sent = 0, beat = 0, outst = 0, beats = 0, bpush = 0;
        int unsigned last_b = 0, done_cyc = 0, aw_cnt = 0, exp_bursts;
        bit finished = 0, aborted = 0, aw_wait = 0, w_wait = 0;
        logic [31:0]   p_awaddr = '0;
        logic [7:0]    p_awlen = '0;
        logic [DW-1:0] p_wdata = '0;
        logic          p_wlast = 1'b0;
        logic [DW-1:0] ed;
        exp_bursts = exp_aw_addr.size();
        r_max_outst = 0;
        r_full_seen = 0;
        slave_len.delete();
        b_due.delete();
        b_resp.delete();
        @(negedge clk);
        base_addr  = base;
        xfer_words = n;
        start      = 1'b1;
        #1;
        check("idle_before_start", 32'(idle), 32'd1);
        while (!finished && cyc < 10000) begin
            @(negedge clk);
            start = (cyc == 40) && (n >= 24'd256);
            if (start) begin
                base_addr  = 32'hDEAD_0000;
                xfer_words = 24'd7;
            end
            s_axis_valid  = (sent < 32'(n));
            s_axis_data   = data_seq;
            m_axi_awready = (cyc % aw_gap) == 0;
            m_axi_wready  = (cyc % w_gap) == 0;
            m_axi_bvalid  = (b_due.size() != 0) && (cyc >= b_due[0]);
            m_axi_bresp   = m_axi_bvalid ? b_resp[0] : 2'b00;
            #1;
            if (cyc == 0) begin
                check("idle_in_xfer", 32'(idle), 32'd0);
                check("bresp_err_cleared", 32'(bresp_err), 32'd0);
            end
            if (sb_data.size() == DEPTH) begin
                r_full_seen = 1;
                check("ready_low_when_full", 32'(s_axis_ready), 32'd0);
            end
            if (s_axis_valid && s_axis_ready) begin
                sb_data.push_back(data_seq);
                data_seq++;
                sent++;
            end
            if (aw_wait) begin
                check("awvalid_held", 32'(m_axi_awvalid), 32'd1);
                check("awaddr_held", m_axi_awaddr, p_awaddr);
                check("awlen_held", 32'(m_axi_awlen), 32'(p_awlen));
            end
            if (m_axi_awvalid && m_axi_awready) begin
                aw_cnt++;
                if (exp_aw_addr.size() == 0) begin
                    check("aw_extra", aw_cnt, exp_bursts);
                end else begin
                    check("awaddr", m_axi_awaddr, exp_aw_addr.pop_front());
                    check("awlen", 32'(m_axi_awlen), 32'(exp_aw_len.pop_front()));
                    check("awsize", 32'(m_axi_awsize), 32'd1);
                end
                slave_len.push_back(m_axi_awlen);
                outst++;
                if (outst > r_max_outst) r_max_outst = outst;
                check("outstd_limit", 32'(outst <= MAXO), 32'd1);
            end
            aw_wait  = m_axi_awvalid && !m_axi_awready;
            p_awaddr = m_axi_awaddr;
            p_awlen  = m_axi_awlen;
            if (w_wait) begin
                check("wvalid_held", 32'(m_axi_wvalid), 32'd1);
                check("wdata_held", 32'(m_axi_wdata), 32'(p_wdata));
                check("wlast_held", 32'(m_axi_wlast), 32'(p_wlast));
            end
            if (m_axi_wvalid && m_axi_wready) begin
                check("w_after_aw", 32'(slave_len.size() != 0), 32'd1);
                ed = (sb_data.size() != 0) ? sb_data.pop_front() : 'x;
                check("wdata", 32'(m_axi_wdata), 32'(ed));
                check("wstrb", 32'(m_axi_wstrb), 32'h3);
                if (slave_len.size() != 0) begin
                    check("wlast", 32'(m_axi_wlast), 32'(beat == 32'(slave_len[0])));
                    if (beat == 32'(slave_len[0])) begin
                        void'(slave_len.pop_front());
                        beat = 0;
                        b_due.push_back(cyc + bdel);
                        b_resp.push_back((bpush == err_at) ? 2'b10 : 2'b00);
                        bpush++;
                    end else begin
                        beat++;
                    end
                end
                beats++;
            end
            w_wait  = m_axi_wvalid && !m_axi_wready;
            p_wdata = m_axi_wdata;
            p_wlast = m_axi_wlast;
            if (m_axi_bvalid && m_axi_bready) begin
                void'(b_due.pop_front());
                void'(b_resp.pop_front());
                outst--;
                last_b = cyc;
            end
            if (done) begin
                done_cyc = cyc;
                finished = 1;
            end
            if (abort_beat != 0 && beats >= abort_beat) begin
                #1 rst_n = 1'b0;
                #1;
                check("rst_idle", 32'(idle), 32'd1);
                check("rst_awvalid", 32'(m_axi_awvalid), 32'd0);
                check("rst_wvalid", 32'(m_axi_wvalid), 32'd0);
                check("rst_s_ready", 32'(s_axis_ready), 32'd0);
                check("rst_bready", 32'(m_axi_bready), 32'd0);
                finished = 1;
                aborted  = 1;
            end
            cyc++;
        end
        s_axis_valid  = 1'b0;
        m_axi_bvalid  = 1'b0;
        m_axi_awready = 1'b0;
        m_axi_wready  = 1'b0;
        start         = 1'b0;
        if (!finished) begin
            check("done_timeout", cyc, 32'd0);
        end else if (!aborted) begin
            check("done_cycle", done_cyc, (n == 24'd0) ? 32'd0 : last_b + 2);
            check("beats", beats, 32'(n));
            check("aw_all_issued", exp_aw_addr.size(), 32'd0);
            check("bresp_err", 32'(bresp_err), 32'(exp_err));
            check("outst_end", outst, 32'd0);
            @(negedge clk);
            #1;
            check("done_pulse_width", 32'(done), 32'd0);
            check("idle_after", 32'(idle), 32'd1);
            check("bresp_err_held", 32'(bresp_err), 32'(exp_err));
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; base_addr = '0; xfer_words = '0;
        s_axis_data = '0; s_axis_valid = 1'b0;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bresp = 2'b00; m_axi_bvalid = 1'b0;
        data_seq = 16'h1000;
        repeat (3) @(negedge clk);
        #1;
        check("reset_idle", 32'(idle), 32'd1);
        check("reset_done", 32'(done), 32'd0);
        check("reset_awvalid", 32'(m_axi_awvalid), 32'd0);
        check("reset_awlen", 32'(m_axi_awlen), 32'd0);
        check("reset_wvalid", 32'(m_axi_wvalid), 32'd0);
        check("reset_wlast", 32'(m_axi_wlast), 32'd0);
        check("reset_s_ready", 32'(s_axis_ready), 32'd0);
        check("reset_bready", 32'(m_axi_bready), 32'd0);
        check("reset_bresp_err", 32'(bresp_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        add_aw(32'h0000, 8'd255); add_aw(32'h0200, 8'd255);
        run_xfer(32'h0000, 24'd512, 1, 1, 2, 99, 0, 1'b0);

        add_aw(32'h0000, 8'd255); add_aw(32'h0200, 8'd43);
        run_xfer(32'h0000, 24'd300, 1, 1, 3, 99, 0, 1'b0);

        add_aw(32'h0F00, 8'd127); add_aw(32'h1000, 8'd127);
        run_xfer(32'h0F00, 24'd256, 2, 1, 4, 99, 0, 1'b0);

        add_aw(32'h2000, 8'd255); add_aw(32'h2200, 8'd255);
        add_aw(32'h2400, 8'd255); add_aw(32'h2600, 8'd255);
        run_xfer(32'h2000, 24'd1024, 1, 4, 200, 99, 0, 1'b0);
        check("outstd_reached_max", r_max_outst, 32'(MAXO));
        check("fifo_full_seen", 32'(r_full_seen), 32'd1);

        add_aw(32'h0FFE, 8'd0); add_aw(32'h1000, 8'd1);
        run_xfer(32'h0FFE, 24'd3, 1, 1, 2, 99, 0, 1'b0);

        add_aw(32'h4000, 8'd255); add_aw(32'h4200, 8'd255);
        run_xfer(32'h4000, 24'd512, 3, 2, 5, 1, 0, 1'b1);

        run_xfer(32'h5000, 24'd0, 1, 1, 2, 99, 0, 1'b0);

        add_aw(32'h0000, 8'd255); add_aw(32'h0200, 8'd255);
        run_xfer(32'h0000, 24'd512, 1, 1, 2, 99, 20, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_aw_addr.delete();
        exp_aw_len.delete();
        sb_data.delete();
        @(negedge clk);
        #1;
        check("post_reset_idle", 32'(idle), 32'd1);
        check("post_reset_awvalid", 32'(m_axi_awvalid), 32'd0);

        add_aw(32'h0100, 8'd3);
        run_xfer(32'h0100, 24'd4, 1, 1, 2, 99, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
